// File: rtl/a2b_dir_ctrl.sv
// Direction controller for the 16-bit A/B bus exchange: arbitrates A/B requests,
// drives the oe0 direction bit and enforces a dead time on every reversal.
module a2b_dir_ctrl #(
    parameter int unsigned TURN_CYC = 2,
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic oe0,
    output logic drv_en,
    output logic gnt_a,
    output logic gnt_b,
    output logic turn
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_XFER_A = 2'd1,
        S_XFER_B = 2'd2,
        S_TURN   = 2'd3
    } state_e;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    localparam logic [3:0] TURN_CYC_C = 4'(TURN_CYC);

    state_e     state_q, state_d;
    logic       target_q, target_d;     // 0 = A side, 1 = B side
    logic       last_gnt_q, last_gnt_d; // 0 = A side, 1 = B side
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] turn_cnt_q, turn_cnt_d;
    logic       oe0_q, oe0_d;
    logic       drv_en_q, gnt_a_q, gnt_b_q, turn_q;

    logic       enter_xfer_s, enter_turn_s, dir_s;
    logic [7:0] hold_inc_s;
    logic       tgt_req_s;

    // Next-state, counter and direction decode.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        last_gnt_d   = last_gnt_q;
        hold_cnt_d   = hold_cnt_q;
        turn_cnt_d   = turn_cnt_q;
        oe0_d        = oe0_q;
        enter_xfer_s = 1'b0;
        enter_turn_s = 1'b0;
        dir_s        = oe0_q;
        hold_inc_s   = (hold_cnt_q == 8'hFF) ? 8'hFF : (hold_cnt_q + 8'd1);
        tgt_req_s    = target_q ? req_b : req_a;

        case (state_q)
            S_IDLE: begin
                if (req_a && req_b) begin
                    dir_s = ~last_gnt_q;
                end else if (req_a) begin
                    dir_s = 1'b0;
                end else begin
                    dir_s = 1'b1;
                end
                // A request matching the current direction skips the dead time.
                if (req_a || req_b) begin
                    enter_xfer_s = (dir_s == oe0_q);
                    enter_turn_s = (dir_s != oe0_q);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_XFER_A: begin
                dir_s = 1'b1;
                if (!req_a) begin
                    enter_turn_s = req_b;
                    state_d      = req_b ? S_XFER_A : S_IDLE;
                end else begin
                    hold_cnt_d   = hold_inc_s;
                    enter_turn_s = req_b && (hold_inc_s >= MAX_HOLD_C);
                end
            end
            S_XFER_B: begin
                dir_s = 1'b0;
                if (!req_b) begin
                    enter_turn_s = req_a;
                    state_d      = req_a ? S_XFER_B : S_IDLE;
                end else begin
                    hold_cnt_d   = hold_inc_s;
                    enter_turn_s = req_a && (hold_inc_s >= MAX_HOLD_C);
                end
            end
            S_TURN: begin
                dir_s = target_q;
                // Requests are only looked at once the full dead time has elapsed.
                if (turn_cnt_q >= TURN_CYC_C) begin
                    enter_xfer_s = tgt_req_s;
                    state_d      = S_IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case ({enter_xfer_s, enter_turn_s})
            2'b10: begin
                state_d    = dir_s ? S_XFER_B : S_XFER_A;
                hold_cnt_d = 8'd0;
                last_gnt_d = dir_s;
                oe0_d      = dir_s;
            end
            2'b01: begin
                state_d    = S_TURN;
                target_d   = dir_s;
                turn_cnt_d = 4'd1;
                oe0_d      = dir_s;
            end
            default: ;
        endcase
    end

    // State and registered-output update; outputs decode from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            target_q   <= 1'b0;
            last_gnt_q <= 1'b1;
            hold_cnt_q <= 8'd0;
            turn_cnt_q <= 4'd0;
            oe0_q      <= 1'b0;
            drv_en_q   <= 1'b0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            turn_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            last_gnt_q <= last_gnt_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            oe0_q      <= oe0_d;
            drv_en_q   <= (state_d == S_XFER_A) || (state_d == S_XFER_B);
            gnt_a_q    <= (state_d == S_XFER_A);
            gnt_b_q    <= (state_d == S_XFER_B);
            turn_q     <= (state_d == S_TURN);
        end
    end

    assign oe0    = oe0_q;
    assign drv_en = drv_en_q;
    assign gnt_a  = gnt_a_q;
    assign gnt_b  = gnt_b_q;
    assign turn   = turn_q;

endmodule

// File: tb/tb_a2b_dir_ctrl.sv
// Directed bench for a2b_dir_ctrl (TURN_CYC=2, MAX_HOLD=15) with an always-on
// direction/dead-time monitor.
module tb_a2b_dir_ctrl;

    localparam int TURN_CYC = 2;
    localparam int MAX_HOLD = 15;

    // Expected {oe0, drv_en, gnt_a, gnt_b, turn}
    localparam logic [4:0] O_IDLE0 = 5'b00000;
    localparam logic [4:0] O_IDLE1 = 5'b10000;
    localparam logic [4:0] O_XA    = 5'b01100;
    localparam logic [4:0] O_XB    = 5'b11010;
    localparam logic [4:0] O_TB    = 5'b10001;
    localparam logic [4:0] O_TA    = 5'b00001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_a = 1'b0;
    logic req_b = 1'b0;
    logic oe0, drv_en, gnt_a, gnt_b, turn;

    int vectors = 0;
    int miscompares = 0;

    a2b_dir_ctrl #(.TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req_a (req_a),
        .req_b (req_b),
        .oe0   (oe0),
        .drv_en(drv_en),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .turn  (turn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {oe0, drv_en, gnt_a, gnt_b, turn};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: {oe0,drv_en,gnt_a,gnt_b,turn} got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_n(input string tag, input logic [4:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, exp);
            step();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", O_IDLE0);
        rst_n = 1'b1;
    endtask

    // Monitor: oe0 stable while driving, no double grant, dead time on reversals.
    logic prev_oe0;
    logic prev_valid = 1'b0;
    logic last_dir = 1'b0;
    int   zero_run = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            zero_run   = 0;
            last_dir   = 1'b0;
        end else begin
            if (prev_valid) begin
                vectors++;
                assert (!((oe0 !== prev_oe0) && drv_en)) else begin
                    miscompares++;
                    $error("FAIL oe0_while_drv: oe0 %b->%b drv_en %b expected drv_en 0", prev_oe0, oe0, drv_en);
                end
            end
            vectors++;
            assert (!(gnt_a && gnt_b) && (drv_en === (gnt_a | gnt_b))) else begin
                miscompares++;
                $error("FAIL grant_excl: gnt_a %b gnt_b %b drv_en %b expected exclusive grants and drv_en=gnt_a|gnt_b", gnt_a, gnt_b, drv_en);
            end
            if (drv_en) begin
                if (oe0 !== last_dir) begin
                    vectors++;
                    assert (zero_run >= TURN_CYC) else begin
                        miscompares++;
                        $error("FAIL dead_time: got %0d idle cycles expected >= %0d", zero_run, TURN_CYC);
                    end
                end
                last_dir = oe0;
                zero_run = 0;
            end else begin
                zero_run++;
            end
            prev_oe0   = oe0;
            prev_valid = 1'b1;
        end
    end

    initial begin
        // First A request after reset: one-cycle grant, unlimited hold, then preempt.
        do_reset();
        req_a = 1'b1;
        step();
        expect_n("gnt_a_first", O_XA, 20);
        req_b = 1'b1;
        step();
        check("preempt_turn", O_TB);
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        check("preempt_turn2", O_TB);
        step();
        check("withdrawn_idle", O_IDLE1);

        // B request after reset: dead time, then grant; async reset mid-XFER_B.
        do_reset();
        req_b = 1'b1;
        step();
        expect_n("turn_to_b", O_TB, 2);
        check("gnt_b_after_turn", O_XB);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", O_IDLE0);
        req_b = 1'b0;

        // Both requesting: 15-cycle alternation with 2-cycle turns.
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        expect_n("alt_a", O_XA, MAX_HOLD);
        expect_n("alt_turn_b", O_TB, TURN_CYC);
        expect_n("alt_b", O_XB, MAX_HOLD);
        expect_n("alt_turn_a", O_TA, TURN_CYC);
        expect_n("alt_a2", O_XA, MAX_HOLD);
        check("alt_turn_b2", O_TB);

        // Turn is not aborted; IDLE keeps new direction; last_gnt tie-break.
        do_reset();
        req_b = 1'b1;
        step();
        check("abort_t1", O_TB);
        req_b = 1'b0;
        step();
        check("abort_t2", O_TB);
        step();
        expect_n("idle_oe1", O_IDLE1, 2);
        req_b = 1'b1;
        step();
        check("same_dir_gnt_b", O_XB);
        req_a = 1'b1;
        req_b = 1'b0;
        step();
        expect_n("handover_turn_a", O_TA, TURN_CYC);
        check("handover_gnt_a", O_XA);
        req_a = 1'b0;
        step();
        check("idle_oe0", O_IDLE0);
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        expect_n("tie_turn_b", O_TB, TURN_CYC);
        check("tie_gnt_b", O_XB);
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        check("final_idle", O_IDLE1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
